apb2axi_axi_slave_mem: RTL and testbench
========================================

# apb2axi_axi_slave_mem

AXI3 slave responder with an internal word-addressed memory. It terminates the AXI master port of the APB2AXI bridge, covering the AW/W/B and AR/R channels, and serves as the bridge's downstream target in block- and top-level benches. Write and read paths are independent FSMs that share one memory array. Each path supports FIXED, INCR and WRAP bursts, narrow transfers, byte strobes and SLVERR signalling.

## Interface
- AXI_ADDR_W, 32, address width
- AXI_DATA_W, 64, data width; power of 2, at least 32
- AXI_ID_W, 4, ID width
- MEM_DEPTH, 1024, memory depth in AXI_DATA_W words
- BASE_ADDR, 0, byte address of word 0
- aclk  in  1  single clock; all logic on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  in  AXI_ID_W/AXI_ADDR_W/4/3/2  write address payload
- awlock/awcache/awprot  in  1/4/3  accepted and ignored
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  AXI_DATA_W/AXI_DATA_W/8/1  write data payload
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  AXI_ID_W/2  write response payload
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arburst  in  AXI_ID_W/AXI_ADDR_W/4/3/2  read address payload
- arlock/arcache/arprot  in  1/4/3  accepted and ignored
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  AXI_ID_W/AXI_DATA_W/2/1  read data payload
- rvalid out 1, rready in 1  read data handshake

## Operation
- **Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE.**
  - W_IDLE: awready=1. AW handshake captures id, addr, len, size and burst, clears the beat counter and the error flag.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb to mem[idx], advances the address and increments the beat counter. The beat with counter==len moves the FSM to W_RESP.
  - W_RESP: bvalid=1, bid=captured id. B handshake returns to W_IDLE.
- **Read FSM, R_IDLE → R_DATA → R_IDLE.**
  - R_IDLE: arready=1. AR handshake captures the command and loads beat 0 into the R registers.
  - R_DATA: rvalid=1. On each R handshake the next beat is loaded. Handshake on the beat with rlast=1 returns to R_IDLE.
- **Address arithmetic.**
  - Word index: idx = (addr − BASE_ADDR) >> log2(AXI_DATA_W/8). Subtraction is modulo 2^AXI_ADDR_W.
  - Step: INCR adds 2^size. FIXED adds 0.
  - WRAP: container = (len+1)·2^size, aligned down to that size; address = container_base + ((addr + 2^size) mod container).
- **Errors (bresp/rresp = 2'b10, SLVERR).** Any one of the following is an error:
  - idx ≥ MEM_DEPTH, checked per beat;
  - 2^size > AXI_DATA_W/8;
  - burst==2'b11;
  - WRAP with len ∉ {1,3,7,15};
  - on writes only, wlast not matching (counter==len).
- **Error consequences.**
  - Write beats that hit an error leave memory unmodified. The error is sticky for the burst and reported on bresp.
  - Read beats that hit an error return rdata=0 with rresp=SLVERR. Other beats return rresp=OKAY (2'b00).
- **Memory.** Not reset. A write in cycle N is visible to an R beat loaded in cycle N+1 or later. An R beat already presented is never altered by a later write.

## Timing
- **Reset values.** All of awready, wready, bvalid, arready, rvalid and rlast reset to 0. bid, bresp, rid, rdata and rresp reset to 0. Both FSMs reset to IDLE.
- **Ready after reset.** A ready-enable flop holds awready and arready at 0 until the first edge after aresetn deasserts. Both read 1 at that edge.
- **Write latency.** AW handshake at edge N gives wready=1 from N+1. W beats complete back-to-back when wvalid is held. The last W handshake at M gives bvalid=1 at M+1. B handshake at K gives awready=1 at K+1. W data offered before AW stalls (wready=0).
- **Read latency.** AR handshake at N gives rvalid=1 with beat 0 at N+1. A burst with rready held high completes in len+1 cycles. The rlast handshake at M gives arready=1 at M+1.
- **Stability.** rid, rdata, rresp and rlast, and bid and bresp, stay stable while valid=1 and ready=0.
- **Concurrency.** Both FSMs run concurrently. A W beat and an R load to the same idx in the same cycle: R returns the pre-write data.
- **Reset mid-burst.** Both FSMs go to IDLE immediately and every output takes its reset value. Partially written bursts remain in memory.
- **Single-beat bursts.** len=0 is legal for all burst types except WRAP, which flags SLVERR.

## Test plan
- Write INCR, awaddr=0x100, len=3, size=3, data 0x11..0x44, wstrb=0xFF, then read the same range → bresp=0, rdata sequence 0x11,0x22,0x33,0x44, rlast on beat 3 only, rid=arid.
- Narrow write: size=2, awaddr=0x204, wdata=0xAABBCCDD_00000000, wstrb=0xF0 → read at 0x200 returns upper word 0xAABBCCDD and lower word unchanged.
- WRAP read at 0x118, len=3, size=3 → addresses 0x118, 0x100, 0x108, 0x110.
- Out-of-range write at BASE_ADDR + MEM_DEPTH·8 → bresp=2'b10, memory untouched. Read there → rdata=0, rresp=2'b10.
- Backpressure: rready toggling 1/0 and bready held 0 for 5 cycles → payloads stable while stalled, no beats lost, arready/awready stay 0 until the burst completes.
- Overlap: write burst and read burst issued in the same cycle → both complete. aresetn pulsed mid-read → rvalid=0 immediately, arready=1 on the first edge after release.

Source files
------------

// File: rtl/apb2axi_axi_slave_mem.sv
// apb2axi_axi_slave_mem: AXI3 slave responder backed by a word-addressed memory
module apb2axi_axi_slave_mem #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ID_W = 4,
    parameter int MEM_DEPTH = 1024,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [AXI_ID_W-1:0]     awid,
    input  logic [AXI_ADDR_W-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awlock,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AXI_DATA_W-1:0]   wdata,
    input  logic [AXI_DATA_W/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [AXI_ID_W-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [AXI_ID_W-1:0]     arid,
    input  logic [AXI_ADDR_W-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [AXI_ID_W-1:0]     rid,
    output logic [AXI_DATA_W-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int NB = AXI_DATA_W / 8;
    localparam int SH = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic addr_t next_addr(addr_t a, logic [3:0] len, logic [2:0] size, logic [1:0] burst);
        addr_t inc, msk;
        inc = addr_t'(1) << size;
        msk = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~msk) | ((a + inc) & msk) : a + inc;
    endfunction

    function automatic logic cmd_err(logic [3:0] len, logic [2:0] size, logic [1:0] burst);
        return size > 3'(SH) || burst == 2'b11 || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic addr_t word_idx(addr_t a);
        return (a - BASE_ADDR) >> SH;
    endfunction

    logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];
    w_state_t w_state;
    r_state_t r_state;
    logic [AXI_ID_W-1:0] w_id;
    addr_t w_addr, r_addr, w_idx, ld_addr, ld_idx;
    logic [3:0] w_len, r_len, w_cnt, r_cnt, ld_len;
    logic [2:0] w_size, r_size, ld_size;
    logic [1:0] w_burst, r_burst, ld_burst;
    logic w_sticky, w_err, w_fire, ld_err;
    logic [AXI_DATA_W-1:0] ld_data;
    logic unused;

    assign unused = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot};
    assign w_idx = word_idx(w_addr);
    assign w_fire = wvalid && wready;
    assign w_err = cmd_err(w_len, w_size, w_burst) || w_idx >= addr_t'(MEM_DEPTH) || (wlast != (w_cnt == w_len));
    assign ld_addr = r_state == R_IDLE ? araddr : r_addr;
    assign ld_len = r_state == R_IDLE ? arlen : r_len;
    assign ld_size = r_state == R_IDLE ? arsize : r_size;
    assign ld_burst = r_state == R_IDLE ? arburst : r_burst;
    assign ld_idx = word_idx(ld_addr);
    assign ld_err = cmd_err(ld_len, ld_size, ld_burst) || ld_idx >= addr_t'(MEM_DEPTH);
    assign ld_data = ld_err ? '0 : mem[ld_idx[IW-1:0]];

    // Byte-strobed memory write for error-free W beats; memory is never reset
    always_ff @(posedge aclk) begin
        if (w_fire && !w_err)
            for (int b = 0; b < NB; b++)
                if (wstrb[b]) mem[w_idx[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
    end

    // Write FSM: accept AW, absorb W beats, then hold B until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bid <= '0;
            bresp <= 2'b00;
            w_id <= '0;
            w_addr <= '0;
            w_len <= '0;
            w_size <= '0;
            w_burst <= '0;
            w_cnt <= '0;
            w_sticky <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= !(awvalid && awready);
                    if (awvalid && awready) begin
                        w_state <= W_DATA;
                        wready <= 1'b1;
                        w_id <= awid;
                        w_addr <= awaddr;
                        w_len <= awlen;
                        w_size <= awsize;
                        w_burst <= awburst;
                        w_cnt <= '0;
                        w_sticky <= 1'b0;
                    end
                end
                W_DATA: if (w_fire) begin
                    w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                    w_cnt <= w_cnt + 4'd1;
                    w_sticky <= w_sticky || w_err;
                    if (w_cnt == w_len) begin
                        w_state <= W_RESP;
                        wready <= 1'b0;
                        bvalid <= 1'b1;
                        bid <= w_id;
                        bresp <= (w_sticky || w_err) ? 2'b10 : 2'b00;
                    end
                end
                default: if (bready) begin
                    w_state <= W_IDLE;
                    bvalid <= 1'b0;
                    awready <= 1'b1;
                end
            endcase
        end
    end

    // Read FSM: load beat 0 on AR, then the next beat on each R handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rlast <= 1'b0;
            rid <= '0;
            rdata <= '0;
            rresp <= 2'b00;
            r_addr <= '0;
            r_len <= '0;
            r_size <= '0;
            r_burst <= '0;
            r_cnt <= '0;
        end else if (r_state == R_IDLE) begin
            arready <= !(arvalid && arready);
            if (arvalid && arready) begin
                r_state <= R_DATA;
                rvalid <= 1'b1;
                rid <= arid;
                rdata <= ld_data;
                rresp <= ld_err ? 2'b10 : 2'b00;
                rlast <= arlen == 4'd0;
                r_len <= arlen;
                r_size <= arsize;
                r_burst <= arburst;
                r_addr <= next_addr(araddr, arlen, arsize, arburst);
                r_cnt <= 4'd1;
            end
        end else if (rready) begin
            if (rlast) begin
                r_state <= R_IDLE;
                rvalid <= 1'b0;
                rlast <= 1'b0;
                arready <= 1'b1;
            end else begin
                rdata <= ld_data;
                rresp <= ld_err ? 2'b10 : 2'b00;
                rlast <= r_cnt == r_len;
                r_cnt <= r_cnt + 4'd1;
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            end
        end
    end
endmodule

// File: tb/tb_apb2axi_axi_slave_mem.sv
// tb_apb2axi_axi_slave_mem: scoreboard bench for the AXI slave memory
module tb_apb2axi_axi_slave_mem;
    typedef struct packed {logic [63:0] d; logic [1:0] resp; logic last; logic [3:0] id;} beat_t;

    logic aclk = 0, aresetn = 0;
    logic [3:0] awid = 0, arid = 0, bid, rid;
    logic [31:0] awaddr = 0, araddr = 0;
    logic [3:0] awlen = 0, arlen = 0, awcache = 0, arcache = 0;
    logic [2:0] awsize = 0, arsize = 0, awprot = 0, arprot = 0;
    logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
    logic awlock = 0, arlock = 0, awvalid = 0, arvalid = 0, wvalid = 0, wlast = 0, bready = 0, rready = 0;
    logic awready, arready, wready, bvalid, rvalid, rlast;
    logic [63:0] wdata = 0, rdata;
    logic [7:0] wstrb = 0;

    int tests = 0, fails = 0, tmo = 0;
    beat_t exp_q[$], got_q[$];
    logic [1:0] bexp_q[$];

    apb2axi_axi_slave_mem dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
        bit r;
        awaddr = a; awlen = l; awsize = s; awburst = b; awid = id; awvalid = 1;
        for (int i = 0; i < 100; i++) begin
            r = awready;
            @(posedge aclk); #1;
            if (r) break;
            if (i == 99) tmo++;
        end
        awvalid = 0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
        bit r;
        araddr = a; arlen = l; arsize = s; arburst = b; arid = id; arvalid = 1;
        for (int i = 0; i < 100; i++) begin
            r = arready;
            @(posedge aclk); #1;
            if (r) break;
            if (i == 99) tmo++;
        end
        arvalid = 0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic l);
        bit r;
        wdata = d; wstrb = st; wlast = l; wvalid = 1;
        for (int i = 0; i < 100; i++) begin
            r = wready;
            @(posedge aclk); #1;
            if (r) break;
            if (i == 99) tmo++;
        end
        wvalid = 0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        bit r;
        resp = 'x; id = 'x;
        bready = 1;
        for (int i = 0; i < 100; i++) begin
            r = bvalid; resp = bresp; id = bid;
            @(posedge aclk); #1;
            if (r) break;
            if (i == 99) begin tmo++; resp = 'x; end
        end
        bready = 0;
    endtask

    task automatic recv_r(input int n);
        bit r;
        beat_t bt;
        int got = 0;
        rready = 1;
        for (int i = 0; i < 200 && got < n; i++) begin
            r = rvalid; bt = '{d: rdata, resp: rresp, last: rlast, id: rid};
            @(posedge aclk); #1;
            if (r) begin got_q.push_back(bt); got++; end
        end
        if (got < n) tmo++;
        rready = 0;
    endtask

    task automatic test_reset;
        aresetn = 0;
        repeat (2) @(posedge aclk);
        #1;
        tests++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {awready, wready, bvalid, arready, rvalid, rlast, bid, bresp, rid, rdata, rresp});
        end
        @(negedge aclk);
        aresetn = 1;
        #1;
        tests++;
        if ({awready, arready} !== 2'b00) begin fails++; $display("FAIL ready_before_edge got=%b exp=00", {awready, arready}); end
        @(posedge aclk); #1;
        tests++;
        if ({awready, arready} !== 2'b11) begin fails++; $display("FAIL ready_after_edge got=%b exp=11", {awready, arready}); end
    endtask

    task automatic test_incr;
        logic [1:0] resp;
        logic [3:0] id;
        beat_t e, g;
        bexp_q.push_back(2'b00);
        send_aw(32'h100, 3, 3, 2'b01, 4'd5);
        tests++;
        if (wready !== 1'b1) begin fails++; $display("FAIL incr_wready got=%b exp=1", wready); end
        for (int i = 0; i < 4; i++) send_w(64'(17 * (i + 1)), 8'hFF, i == 3);
        tests++;
        if (bvalid !== 1'b1) begin fails++; $display("FAIL incr_bvalid_latency got=%b exp=1", bvalid); end
        wait_b(resp, id);
        tests++;
        if ({resp, id} !== {bexp_q.pop_front(), 4'd5}) begin fails++; $display("FAIL incr_b got=%h/%h exp=0/5", resp, id); end
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: 64'(17 * (i + 1)), resp: 2'b00, last: i == 3, id: 4'd9});
        send_ar(32'h100, 3, 3, 2'b01, 4'd9);
        tests++;
        if (rvalid !== 1'b1) begin fails++; $display("FAIL incr_rvalid_latency got=%b exp=1", rvalid); end
        recv_r(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL incr_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_narrow;
        logic [1:0] resp;
        logic [3:0] id;
        beat_t e, g;
        bexp_q.push_back(2'b00);
        bexp_q.push_back(2'b00);
        send_aw(32'h200, 0, 3, 2'b01, 4'd1);
        send_w(64'h11223344_55667788, 8'hFF, 1);
        wait_b(resp, id);
        tests++;
        if (resp !== bexp_q.pop_front()) begin fails++; $display("FAIL narrow_fill_bresp got=%h exp=0", resp); end
        send_aw(32'h204, 0, 2, 2'b01, 4'd2);
        send_w(64'hAABBCCDD_00000000, 8'hF0, 1);
        wait_b(resp, id);
        tests++;
        if ({resp, id} !== {bexp_q.pop_front(), 4'd2}) begin fails++; $display("FAIL narrow_b got=%h/%h exp=0/2", resp, id); end
        exp_q.push_back('{d: 64'hAABBCCDD_55667788, resp: 2'b00, last: 1'b1, id: 4'd7});
        send_ar(32'h200, 0, 3, 2'b01, 4'd7);
        recv_r(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL narrow_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_wrap;
        beat_t e, g;
        exp_q.push_back('{d: 64'h44, resp: 2'b00, last: 1'b0, id: 4'd3});
        exp_q.push_back('{d: 64'h11, resp: 2'b00, last: 1'b0, id: 4'd3});
        exp_q.push_back('{d: 64'h22, resp: 2'b00, last: 1'b0, id: 4'd3});
        exp_q.push_back('{d: 64'h33, resp: 2'b00, last: 1'b1, id: 4'd3});
        send_ar(32'h118, 3, 3, 2'b10, 4'd3);
        recv_r(4);
        for (int i = 0; i < 3; i++) exp_q.push_back('{d: 64'h0, resp: 2'b10, last: i == 2, id: 4'd4});
        send_ar(32'h100, 2, 3, 2'b10, 4'd4);
        recv_r(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL wrap_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_errors;
        logic [1:0] resp;
        logic [3:0] id;
        beat_t e, g;
        bexp_q.push_back(2'b00);
        send_aw(32'h1FF8, 0, 3, 2'b01, 4'd0);
        send_w(64'hCAFE, 8'hFF, 1);
        wait_b(resp, id);
        tests++;
        if (resp !== bexp_q.pop_front()) begin fails++; $display("FAIL err_fill_bresp got=%h exp=0", resp); end
        bexp_q.push_back(2'b10);
        send_aw(32'h2000, 0, 3, 2'b01, 4'd0);
        send_w(64'hDEAD, 8'hFF, 1);
        wait_b(resp, id);
        tests++;
        if (resp !== bexp_q.pop_front()) begin fails++; $display("FAIL err_oor_bresp got=%h exp=2", resp); end
        bexp_q.push_back(2'b10);
        send_aw(32'h100, 0, 3, 2'b11, 4'd0);
        send_w(64'hBAD, 8'hFF, 1);
        wait_b(resp, id);
        tests++;
        if (resp !== bexp_q.pop_front()) begin fails++; $display("FAIL err_burst3_bresp got=%h exp=2", resp); end
        bexp_q.push_back(2'b10);
        send_aw(32'h108, 0, 3, 2'b10, 4'd0);
        send_w(64'hBAD, 8'hFF, 1);
        wait_b(resp, id);
        tests++;
        if (resp !== bexp_q.pop_front()) begin fails++; $display("FAIL err_wrap0_bresp got=%h exp=2", resp); end
        exp_q.push_back('{d: 64'hCAFE, resp: 2'b00, last: 1'b0, id: 4'd8});
        exp_q.push_back('{d: 64'h0, resp: 2'b10, last: 1'b1, id: 4'd8});
        send_ar(32'h1FF8, 1, 3, 2'b01, 4'd8);
        recv_r(2);
        exp_q.push_back('{d: 64'h11, resp: 2'b00, last: 1'b0, id: 4'd2});
        exp_q.push_back('{d: 64'h22, resp: 2'b00, last: 1'b1, id: 4'd2});
        send_ar(32'h100, 1, 3, 2'b01, 4'd2);
        recv_r(2);
        exp_q.push_back('{d: 64'h0, resp: 2'b10, last: 1'b1, id: 4'd6});
        send_ar(32'h100, 0, 4, 2'b01, 4'd6);
        recv_r(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL err_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] resp;
        logic [3:0] id;
        beat_t e, g, cur, snap;
        bit stalled = 0, hs;
        int got = 0;
        bexp_q.push_back(2'b00);
        send_aw(32'h400, 1, 3, 2'b01, 4'd6);
        send_w(64'hA1, 8'hFF, 0);
        send_w(64'hB2, 8'hFF, 1);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({bvalid, bid, bresp, awready} !== {1'b1, 4'd6, 2'b00, 1'b0}) begin
                fails++; $display("FAIL bp_b_hold got=%h exp=%h", {bvalid, bid, bresp, awready}, {1'b1, 4'd6, 2'b00, 1'b0});
            end
            @(posedge aclk); #1;
        end
        wait_b(resp, id);
        tests++;
        if ({resp, id} !== {bexp_q.pop_front(), 4'd6}) begin fails++; $display("FAIL bp_b got=%h/%h exp=0/6", resp, id); end
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: 64'(17 * (i + 1)), resp: 2'b00, last: i == 3, id: 4'd10});
        send_ar(32'h100, 3, 3, 2'b01, 4'd10);
        for (int k = 0; k < 100 && got < 4; k++) begin
            cur = '{d: rdata, resp: rresp, last: rlast, id: rid};
            if (stalled) begin
                tests++;
                if (cur !== snap) begin fails++; $display("FAIL bp_r_stable got=%h exp=%h", cur, snap); end
            end
            if (rvalid) begin
                tests++;
                if (arready !== 1'b0) begin fails++; $display("FAIL bp_arready got=%b exp=0", arready); end
            end
            rready = (k % 2 == 1);
            stalled = rvalid && !rready;
            hs = rvalid && rready;
            snap = cur;
            @(posedge aclk); #1;
            if (hs) begin got_q.push_back(cur); got++; end
        end
        rready = 0;
        if (got < 4) tmo++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL bp_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_overlap;
        logic [1:0] resp;
        logic [3:0] id;
        beat_t e, g;
        bexp_q.push_back(2'b00);
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: 64'(17 * (i + 1)), resp: 2'b00, last: i == 3, id: 4'd4});
        fork
            begin
                send_aw(32'h300, 1, 3, 2'b01, 4'd2);
                send_w(64'h5555, 8'hFF, 0);
                send_w(64'h6666, 8'hFF, 1);
                wait_b(resp, id);
            end
            begin
                send_ar(32'h100, 3, 3, 2'b01, 4'd4);
                recv_r(4);
            end
        join
        tests++;
        if ({resp, id} !== {bexp_q.pop_front(), 4'd2}) begin fails++; $display("FAIL ovl_b got=%h/%h exp=0/2", resp, id); end
        exp_q.push_back('{d: 64'h5555, resp: 2'b00, last: 1'b0, id: 4'd1});
        exp_q.push_back('{d: 64'h6666, resp: 2'b00, last: 1'b1, id: 4'd1});
        send_ar(32'h300, 1, 3, 2'b01, 4'd1);
        recv_r(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL ovl_read got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid;
        beat_t e, g;
        exp_q.push_back('{d: 64'h11, resp: 2'b00, last: 1'b0, id: 4'd1});
        send_ar(32'h100, 7, 3, 2'b01, 4'd1);
        recv_r(1);
        #2 aresetn = 0;
        #1;
        tests++;
        if ({rvalid, rlast, rdata, arready} !== '0) begin
            fails++; $display("FAIL mid_reset_outputs got=%h exp=0", {rvalid, rlast, rdata, arready});
        end
        #2 aresetn = 1;
        tests++;
        if (arready !== 1'b0) begin fails++; $display("FAIL mid_arready_before got=%b exp=0", arready); end
        @(posedge aclk); #1;
        tests++;
        if (arready !== 1'b1) begin fails++; $display("FAIL mid_arready_after got=%b exp=1", arready); end
        exp_q.push_back('{d: 64'h22, resp: 2'b00, last: 1'b1, id: 4'd3});
        send_ar(32'h108, 0, 3, 2'b01, 4'd3);
        recv_r(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tests++;
            g = got_q.size() > 0 ? got_q.pop_front() : 'x;
            if (g !== e) begin fails++; $display("FAIL mid_read got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        test_reset;
        test_incr;
        test_narrow;
        test_wrap;
        test_errors;
        test_backpressure;
        test_overlap;
        test_reset_mid;
        tests++;
        if (tmo !== 0 || got_q.size() !== 0) begin
            fails++; $display("FAIL timeouts_or_extra got=%0d/%0d exp=0/0", tmo, got_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
